// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver, optional parity via UART_RX_PARITY_EN
module uart_rx #(
    parameter int NB_DATA    = 8,
    parameter int NB_STOP    = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(NB_DATA - 1);
    localparam logic [3:0] LAST_STOP = 4'(NB_STOP - 1);

    state_t             state;
    logic [3:0]         tick_cnt;
    logic [3:0]         bit_cnt;
    logic [NB_DATA-1:0] shift_reg;
    logic               frame_flag;
    logic               rx_meta;
    logic               rx_s;
`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic            parity_bit;
`endif

    // Line is asynchronous; both flops reset high so reset never looks like a start bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            frame_flag   <= 1'b0;
            o_rx_data    <= '0;
            o_rx_done    <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
`endif
        end else begin
            o_rx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (i_tick) begin
                        if (tick_cnt == 4'd7) begin
                            // Mid start bit: still low means a real frame, otherwise a glitch.
                            if (!rx_s) begin
                                state      <= S_DATA;
                                tick_cnt   <= '0;
                                bit_cnt    <= '0;
                                frame_flag <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == 4'd15) begin
                            for (int i = 0; i < NB_DATA - 1; i++) begin
                                shift_reg[i] <= shift_reg[i+1];
                            end
                            shift_reg[NB_DATA-1] <= rx_s;
                            tick_cnt <= '0;
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= S_PARITY;
`else
                                state   <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (i_tick) begin
                        if (tick_cnt == 4'd15) begin
                            parity_bit <= rx_s;
                            tick_cnt   <= '0;
                            bit_cnt    <= '0;
                            state      <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (i_tick) begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= '0;
                            if (bit_cnt == LAST_STOP) begin
                                // Return to IDLE at mid stop bit so a back-to-back start edge is caught.
                                state       <= S_IDLE;
                                o_rx_data   <= shift_reg;
                                o_frame_err <= frame_flag | ~rx_s;
                                o_rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                o_parity_err <= parity_bit ^ (^shift_reg) ^ ODD;
`endif
                            end else begin
                                bit_cnt    <= bit_cnt + 4'd1;
                                frame_flag <= frame_flag | ~rx_s;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_rx_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_parity_err;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       p;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         n_strobes = 0;
    int         n_frames = 0;
    logic [7:0] last_d = 8'h00;
    logic       last_f = 1'b0;
    logic       last_p = 1'b0;

    uart_rx #(.NB_DATA(8), .NB_STOP(1), .PARITY_ODD(0)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_rx_data   (o_rx_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge i_clk);
            #1;
            i_tick = (cnt == 3);
            cnt = (cnt + 1) % 4;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Compare process: every strobe consumes one expected frame; between strobes outputs must hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                last_d = 8'h00;
                last_f = 1'b0;
                last_p = 1'b0;
            end else if (o_rx_done) begin
                n_strobes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_data", int'(o_rx_data), int'(e.d));
                    chk("frame_err", int'(o_frame_err), int'(e.f));
                    chk("parity_err", int'(o_parity_err), int'(e.p));
                    last_d = e.d;
                    last_f = e.f;
                    last_p = e.p;
                end
            end else begin
                chk("hold_data", int'(o_rx_data), int'(last_d));
                chk("hold_ferr", int'(o_frame_err), int'(last_f));
                chk("hold_perr", int'(o_parity_err), int'(last_p));
            end
        end
    end

    // One full frame on the line; a bad stop is held low only past mid-bit so it cannot pose as a start.
    task automatic drive_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par, input int gap);
        exp_t e;
        e.d = d;
        e.f = bad_stop;
`ifdef UART_RX_PARITY_EN
        e.p = bad_par;
`else
        e.p = 1'b0;
`endif
        exp_q.push_back(e);
        n_frames++;
        i_rx = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = (^d) ^ bad_par;
        clks(BIT_CLKS);
`endif
        if (bad_stop) begin
            i_rx = 1'b0;
            clks(40);
            i_rx = 1'b1;
            clks(BIT_CLKS - 40);
        end else begin
            i_rx = 1'b1;
            clks(BIT_CLKS);
        end
        i_rx = 1'b1;
        clks(gap);
    endtask

    initial begin
        logic [7:0] d81;
        logic [7:0] rd;
        bit         bs;
        bit         bp;
        int         gap;

        i_reset = 1'b1;
        i_rx = 1'b1;
        clks(5);
        chk("reset_data", int'(o_rx_data), 0);
        chk("reset_done", int'(o_rx_done), 0);
        chk("reset_ferr", int'(o_frame_err), 0);
        chk("reset_perr", int'(o_parity_err), 0);
        i_reset = 1'b0;
        clks(100);

        drive_frame(8'hA5, 1'b0, 1'b0, 64);
        chk("a5_strobes", n_strobes, 1);
        chk("a5_data", int'(o_rx_data), 'hA5);
        chk("a5_ferr", int'(o_frame_err), 0);

        drive_frame(8'h00, 1'b0, 1'b0, 0);
        drive_frame(8'hFF, 1'b0, 1'b0, 64);
        chk("b2b_strobes", n_strobes, 3);
        chk("b2b_data", int'(o_rx_data), 'hFF);
        chk("b2b_ferr", int'(o_frame_err), 0);

        i_rx = 1'b0;
        clks(20);
        i_rx = 1'b1;
        clks(200);
        chk("glitch_strobes", n_strobes, 3);
        drive_frame(8'h3C, 1'b0, 1'b0, 64);
        chk("3c_strobes", n_strobes, 4);
        chk("3c_data", int'(o_rx_data), 'h3C);

        drive_frame(8'h55, 1'b1, 1'b0, 100);
        chk("55_data", int'(o_rx_data), 'h55);
        chk("55_ferr", int'(o_frame_err), 1);
        drive_frame(8'h12, 1'b0, 1'b0, 64);
        chk("12_data", int'(o_rx_data), 'h12);
        chk("12_ferr", int'(o_frame_err), 0);

        d81 = 8'h81;
        i_rx = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            i_rx = d81[i];
            clks(BIT_CLKS);
        end
        i_rx = d81[4];
        clks(32);
        i_rx = 1'b1;
        i_reset = 1'b1;
        clks(3);
        chk("midrst_data", int'(o_rx_data), 0);
        chk("midrst_ferr", int'(o_frame_err), 0);
        i_reset = 1'b0;
        clks(200);
        chk("midrst_strobes", n_strobes, 6);
        drive_frame(8'h81, 1'b0, 1'b0, 64);
        chk("81_strobes", n_strobes, 7);
        chk("81_data", int'(o_rx_data), 'h81);

`ifdef UART_RX_PARITY_EN
        drive_frame(8'h07, 1'b0, 1'b0, 64);
        chk("07_par_ok", int'(o_parity_err), 0);
        drive_frame(8'h07, 1'b0, 1'b1, 64);
        chk("07_par_bad", int'(o_parity_err), 1);
`endif

        for (int k = 0; k < 30; k++) begin
            rd = 8'($urandom_range(0, 255));
            bs = ($urandom_range(0, 7) == 0);
            bp = ($urandom_range(0, 7) == 0);
            gap = bs ? (64 + $urandom_range(0, 64)) : ($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 80));
            drive_frame(rd, bs, bp, gap);
        end
        clks(100);

        chk("total_strobes", n_strobes, n_frames);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
